// File: rtl/seq101_pkg.sv
// Shared types and helpers for the seq101 scheduler slice.
//   sched_state_e : scheduler FSM states
//   det_state_e   : "101" detector states
//   rr_next()     : round-robin pick, first asserted request after a pointer
package seq101_pkg;

    typedef enum logic [1:0] {StIdle, StShift, StDone} sched_state_e;

    typedef enum logic [1:0] {DetA, DetB, DetC, DetD} det_state_e;

    // Upper bound on channel count supported by rr_next.
    localparam int unsigned MaxCh = 32;

    // Returns the first index with req set, searching (last+1), (last+2), ...
    // wrapping at n_ch. Returns last when nothing is requested.
    function automatic int unsigned rr_next(input logic [MaxCh-1:0] req,
                                            input int unsigned last,
                                            input int unsigned n_ch);
        int unsigned idx;
        int unsigned pick;
        logic found;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= MaxCh; i++) begin
            // last < n_ch and i <= n_ch, so one subtraction is enough to wrap.
            idx = last + i;
            if (idx >= n_ch) idx = idx - n_ch;
            if (!found && (i <= n_ch) && req[idx[4:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/seq101_sched_if.sv
// Channel-side bus of the seq101 scheduler.
//   req       : per-channel request level
//   data      : channel i word at [i*W +: W]
//   gnt       : one-hot accept pulse
//   busy      : job in progress
//   done      : result-valid pulse
//   done_ch   : channel of the completed job
//   match_cnt : overlapping "101" count of the completed job
// master = producers, slave = scheduler.
interface seq101_sched_if #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 8
);
    localparam int unsigned CW  = $clog2(W) + 1;
    localparam int unsigned CHW = $clog2(N_CH);

    logic [N_CH-1:0]   req;
    logic [N_CH*W-1:0] data;
    logic [N_CH-1:0]   gnt;
    logic              busy;
    logic              done;
    logic [CHW-1:0]    done_ch;
    logic [CW-1:0]     match_cnt;

    modport master (
        output req, data,
        input  gnt, busy, done, done_ch, match_cnt
    );

    modport slave (
        input  req, data,
        output gnt, busy, done, done_ch, match_cnt
    );
endinterface

// File: rtl/seq101_det.sv
// Moore "101" detector, overlapping matches.
//   clk, rst : clock, async active-high reset (to A)
//   clr      : synchronous force to A (start of a job)
//   en       : consume x this cycle
//   x        : serial input bit
//   hit      : x completes "101" (current state C and x=1)
//   state    : current detector state
module seq101_det
    import seq101_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       x,
    output logic       hit,
    output det_state_e state
);

    det_state_e state_d;

    always_comb begin
        state_d = DetA;
        unique case (state)
            DetA: state_d = x ? DetB : DetA;
            DetB: state_d = x ? DetB : DetC;
            DetC: state_d = x ? DetD : DetA;
            DetD: state_d = x ? DetB : DetC;
        endcase
    end

    // Same condition as "next state is D", so no flush cycle is needed.
    assign hit = (state == DetC) && x;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DetA;
        end else if (clr) begin
            state <= DetA;
        end else if (en) begin
            state <= state_d;
        end
    end

endmodule

// File: rtl/seq101_sched.sv
// Round-robin scheduler sharing one "101" detector among N_CH channels.
// A granted word is shifted MSB-first through a freshly cleared detector and
// the overlapping match count is returned tagged with the channel index.
//   clk, rst : clock, async active-high reset
//   bus      : seq101_sched_if slave (req/data in; gnt/busy/done/done_ch/match_cnt out)
module seq101_sched
    import seq101_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 8
) (
    input logic            clk,
    input logic            rst,
    seq101_sched_if.slave  bus
);

    localparam int unsigned CW  = $clog2(W) + 1;
    localparam int unsigned CHW = $clog2(N_CH);

    sched_state_e   state_q;
    logic [W-1:0]   shreg_q;
    logic [CW-1:0]  bitcnt_q;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  match_cnt_q;
    logic [CHW-1:0] cur_ch_q;
    logic [CHW-1:0] last_q;
    logic [CHW-1:0] done_ch_q;
    logic [N_CH-1:0] gnt_q;
    logic           busy_q;
    logic           done_q;

    logic [MaxCh-1:0] req_ext;
    logic [CHW-1:0]   win_idx;
    logic [N_CH-1:0]  win_onehot;
    logic [W-1:0]     win_word;
    logic             start;
    logic             shift_en;
    logic             last_bit;
    logic [CW-1:0]    cnt_inc;
    logic             det_hit;
    det_state_e       det_state;
    logic             unused_det_state;

    always_comb begin
        req_ext             = '0;
        req_ext[N_CH-1:0]   = bus.req;
        win_idx             = CHW'(rr_next(req_ext, 32'(last_q), N_CH));
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
        win_word            = bus.data[win_idx*W +: W];
    end

    assign start    = (state_q == StIdle) && (|bus.req);
    assign shift_en = (state_q == StShift);
    assign last_bit = (bitcnt_q == CW'(W - 1));
    assign cnt_inc  = cnt_q + CW'(det_hit);

    // Detector state is exposed by the sub-module for debug only.
    assign unused_det_state = ^det_state;

    seq101_det u_det (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .en    (shift_en),
        .x     (shreg_q[W-1]),
        .hit   (det_hit),
        .state (det_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            cnt_q       <= '0;
            match_cnt_q <= '0;
            cur_ch_q    <= '0;
            last_q      <= CHW'(N_CH - 1);
            done_ch_q   <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    gnt_q <= '0;
                    if (start) begin
                        gnt_q    <= win_onehot;
                        shreg_q  <= win_word;
                        bitcnt_q <= '0;
                        cnt_q    <= '0;
                        cur_ch_q <= win_idx;
                        last_q   <= win_idx;
                        busy_q   <= 1'b1;
                        state_q  <= StShift;
                    end
                end
                StShift: begin
                    gnt_q    <= '0;
                    shreg_q  <= shreg_q << 1;
                    bitcnt_q <= bitcnt_q + CW'(1);
                    cnt_q    <= cnt_inc;
                    if (last_bit) begin
                        state_q     <= StDone;
                        done_q      <= 1'b1;
                        done_ch_q   <= cur_ch_q;
                        match_cnt_q <= cnt_inc;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.done_ch   = done_ch_q;
    assign bus.match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq101_sched.sv
// Self-checking bench for seq101_sched: directed table, multi-cycle corner
// sequences and randomized jobs against a behavioural model.
module tb_seq101_sched;

    localparam int unsigned N_CH = 4;
    localparam int unsigned W    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   model_last;

    seq101_sched_if #(.N_CH(N_CH), .W(W)) bus ();

    seq101_sched #(.N_CH(N_CH), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           ch;
        logic [W-1:0] word;
        int           exp_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Overlapping "101" windows of the word read MSB-first.
    function automatic int count101(input logic [W-1:0] w);
        int c;
        c = 0;
        for (int i = 0; i + 2 < int'(W); i++) if (w[i +: 3] == 3'b101) c++;
        return c;
    endfunction

    function automatic int rr_model(input logic [N_CH-1:0] r, input int last);
        for (int k = 1; k <= int'(N_CH); k++) begin
            int idx;
            idx = (last + k) % int'(N_CH);
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_word(input int ch, input logic [W-1:0] w);
        logic [N_CH*W-1:0] d;
        for (int c = 0; c < int'(N_CH); c++) d[c*W +: W] = (c == ch) ? w : W'($urandom);
        bus.data = d;
    endtask

    task automatic wait_gnt(input int exp_ch, input string tag, output int t);
        logic [N_CH-1:0] e;
        bit seen;
        e = '0;
        e[exp_ch] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4 * int'(W + 2) + 8; i++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                seen = 1'b1;
                break;
            end
            check({tag, "_idle_busy"}, 32'(bus.busy), 0);
            check({tag, "_idle_done"}, 32'(bus.done), 0);
        end
        t = cyc;
        if (!seen) begin
            check({tag, "_gnt_timeout"}, 0, 1);
        end else begin
            check({tag, "_gnt"}, 32'(bus.gnt), 32'(e));
            check({tag, "_busy_at_gnt"}, 32'(bus.busy), 1);
        end
    endtask

    task automatic wait_done(input int t0, input int exp_ch, input int exp_cnt,
                             input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < int'(W) + 8; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            check({tag, "_shift_busy"}, 32'(bus.busy), 1);
        end
        if (!seen) begin
            check({tag, "_done_timeout"}, 0, 1);
        end else begin
            check({tag, "_latency"}, 32'(cyc - t0), W);
            check({tag, "_done_ch"}, 32'(bus.done_ch), 32'(exp_ch));
            check({tag, "_match_cnt"}, 32'(bus.match_cnt), 32'(exp_cnt));
            check({tag, "_busy_at_done"}, 32'(bus.busy), 1);
        end
    endtask

    // Cycle-level invariants.
    always @(negedge clk) begin
        if (!rst) begin
            check("gnt_done_excl", 32'((bus.gnt != '0) && bus.done), 0);
            check("gnt_onehot", 32'($countones(bus.gnt) <= 1), 1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int t, t2;
        logic [W-1:0] fw[5];
        int fc[5];
        logic [N_CH-1:0] r;
        int exp;
        logic [N_CH*W-1:0] d;

        bus.req  = '0;
        bus.data = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(bus.gnt), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_done_ch", 32'(bus.done_ch), 0);
        check("rst_match_cnt", 32'(bus.match_cnt), 0);
        rst = 1'b0;
        model_last = N_CH - 1;

        // Directed single-requester table; ends with ch1 as last grant.
        vecs[0] = '{ch: 0, word: 8'b10101010, exp_cnt: 3};
        vecs[1] = '{ch: 2, word: 8'b11011011, exp_cnt: 2};
        vecs[2] = '{ch: 2, word: 8'b00000000, exp_cnt: 0};
        vecs[3] = '{ch: 3, word: 8'b00000101, exp_cnt: 1};
        vecs[4] = '{ch: 1, word: 8'b00000010, exp_cnt: 0};
        vecs[5] = '{ch: 1, word: 8'b10000000, exp_cnt: 0};
        for (int v = 0; v < 6; v++) begin
            set_word(vecs[v].ch, vecs[v].word);
            bus.req = '0;
            bus.req[vecs[v].ch] = 1'b1;
            wait_gnt(vecs[v].ch, $sformatf("vec%0d", v), t);
            bus.req = '0;
            wait_done(t, vecs[v].ch, vecs[v].exp_cnt, $sformatf("vec%0d", v));
            model_last = vecs[v].ch;
        end

        // Pointer priority: last=1, req=1010 -> ch3 first, then ch1.
        d = '0;
        d[3*W +: W] = 8'b10110101;
        d[1*W +: W] = 8'b11011011;
        bus.data = d;
        bus.req  = 4'b1010;
        wait_gnt(3, "prio_a", t);
        bus.req = 4'b0010;
        wait_done(t, 3, 3, "prio_a");
        wait_gnt(1, "prio_b", t2);
        check("prio_gap", 32'(t2 - t), W + 2);
        bus.req = '0;
        wait_done(t2, 1, 2, "prio_b");

        // Move pointer to ch3 so ch0 leads the fairness run.
        set_word(3, 8'b11111111);
        bus.req = 4'b1000;
        wait_gnt(3, "pre_fair", t);
        bus.req = '0;
        wait_done(t, 3, 0, "pre_fair");

        // Fairness with all requests held.
        fw[0] = 8'b10101010; fc[0] = 3;
        fw[1] = 8'b11011011; fc[1] = 2;
        fw[2] = 8'b10110101; fc[2] = 3;
        fw[3] = 8'b01000000; fc[3] = 0;
        fw[4] = 8'b00000101; fc[4] = 1;
        set_word(0, fw[0]);
        bus.req = 4'b1111;
        t2 = 0;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(k % 4, $sformatf("fair%0d", k), t);
            if (k > 0) check($sformatf("fair%0d_gap", k), 32'(t - t2), W + 2);
            t2 = t;
            if (k == 4) bus.req = '0;
            else set_word((k + 1) % 4, fw[k + 1]);
            wait_done(t, k % 4, fc[k], $sformatf("fair%0d", k));
        end

        // Reset in the middle of a ch0 job.
        set_word(0, 8'b10101010);
        bus.req = 4'b0001;
        wait_gnt(0, "rst_job", t);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_gnt", 32'(bus.gnt), 0);
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_done", 32'(bus.done), 0);
        check("midrst_done_ch", 32'(bus.done_ch), 0);
        check("midrst_match_cnt", 32'(bus.match_cnt), 0);
        repeat (2) begin
            @(negedge clk);
            check("midrst_hold_done", 32'(bus.done), 0);
        end
        set_word(0, 8'b10110101);
        rst = 1'b0;
        model_last = N_CH - 1;
        wait_gnt(0, "post_rst", t);
        bus.req = '0;
        wait_done(t, 0, 3, "post_rst");
        model_last = 0;

        // Randomized jobs against the model.
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            r = N_CH'($urandom_range(1, (1 << N_CH) - 1));
            for (int c = 0; c < int'(N_CH); c++) d[c*W +: W] = W'($urandom);
            bus.data = d;
            exp = rr_model(r, model_last);
            model_last = exp;
            bus.req = r;
            wait_gnt(exp, $sformatf("rnd%0d", it), t);
            bus.req = '0;
            wait_done(t, exp, count101(d[exp*W +: W]), $sformatf("rnd%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
